// File: rtl/prog_ram_loader.sv
// prog_ram_loader: byte-addressed program RAM. A byte-stream loader with
// valid/ready handshake fills it from an auto-incrementing pointer. A wide
// little-endian read port fetches RD_BYTES bytes from any alignment with a
// 1-cycle latency. MEM_BYTES must be a power of two so address arithmetic
// wraps naturally in ADDRW bits.
module prog_ram_loader #(
    parameter  int MEM_BYTES = 32768,
    parameter  int RD_BYTES  = 4,
    localparam int ADDRW     = $clog2(MEM_BYTES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [ADDRW-1:0]      load_base,
    input  logic [ADDRW:0]        load_len,
    input  logic                  wr_valid,
    input  logic [7:0]            wr_data,
    output logic                  wr_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_overflow,
    output logic [ADDRW:0]        byte_cnt,
    input  logic                  rd_en,
    input  logic [ADDRW-1:0]      rd_addr,
    output logic [8*RD_BYTES-1:0] rd_data,
    output logic                  rd_valid
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDRW-1:0]      r_ptr;
    logic [ADDRW:0]        r_len;
    logic [ADDRW:0]        r_cnt;
    logic                  r_ovf;
    logic [7:0]            r_mem [MEM_BYTES];
    logic [8*RD_BYTES-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  w_xfer;
    logic [ADDRW:0]        w_cnt_inc;
    logic [ADDRW-1:0]      w_raddr [RD_BYTES];

    // A load_start always wins, so a byte offered in the same cycle is dropped.
    assign w_xfer    = wr_valid && (r_state == S_LOAD) && !load_start;
    assign w_cnt_inc = r_cnt + 1'b1;

    // Per-lane read addresses; wrap at the top of memory.
    for (genvar k = 0; k < RD_BYTES; k++) begin : g_raddr
        assign w_raddr[k] = rd_addr + ADDRW'(k);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and state-decoded handshake/status outputs.
    always_comb begin
        w_next    = r_state;
        wr_ready  = 1'b0;
        load_busy = 1'b0;
        load_done = 1'b0;
        case (r_state)
            S_LOAD: begin
                wr_ready  = 1'b1;
                load_busy = 1'b1;
                if (w_xfer && (w_cnt_inc == r_len)) w_next = S_DONE;
            end
            S_DONE:  load_done = 1'b1;
            default: ;
        endcase
        // Restart from any state, including mid-load abort.
        if (load_start) w_next = (load_len == '0) ? S_DONE : S_LOAD;
    end

    // Loader pointer, length, byte counter and sticky wrap flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_len <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (load_start) begin
            r_ptr <= load_base;
            r_len <= load_len;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_xfer) begin
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= w_cnt_inc;
            if (r_ptr == '1) r_ovf <= 1'b1;
        end
    end

    // Memory write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_xfer) r_mem[r_ptr] <= wr_data;
    end

    // Wide read; non-blocking semantics give old data on a same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                for (int k = 0; k < RD_BYTES; k++)
                    r_rd_data[8*k +: 8] <= r_mem[w_raddr[k]];
            end
        end
    end

    assign byte_cnt      = r_cnt;
    assign load_overflow = r_ovf;
    assign rd_data       = r_rd_data;
    assign rd_valid      = r_rd_valid;

endmodule
